// File: rtl/montgomery_conv_pkg.sv
// montgomery_conv_pkg: shared FSM state type and step/counter sizing helpers for Montgomery domain conversion.
package montgomery_conv_pkg;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  function automatic int steps(int nbits, int pbits);
    return nbits / pbits;
  endfunction
  function automatic int cnt_w(int nbits, int pbits);
    int n = nbits / pbits;
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mod_double_step.sv
// mod_double_step: one combinational modular doubling y = 2x mod m, assuming x < m.
module mod_double_step #(
  parameter int NBITS = 2048
) (
  input  logic [NBITS-1:0] x,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] y
);
  logic [NBITS:0] d;
  logic           ge;
  assign d  = {x, 1'b0};
  assign ge = d >= {1'b0, m};
  // When x < m the reduced value fits back into NBITS bits.
  assign y  = ge ? NBITS'(d - {1'b0, m}) : NBITS'(d);
endmodule

// File: rtl/montgomery_to_conv.sv
// montgomery_to_conv: iterative conversion y = a * 2^NBITS mod m using PBITS chained modular doublings per cycle.
module montgomery_to_conv
  import montgomery_conv_pkg::*;
#(
  parameter int NBITS = 2048,
  parameter int PBITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] y,
  output logic             done_irq_p
);
  localparam int N  = steps(NBITS, PBITS);
  localparam int CW = cnt_w(NBITS, PBITS);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_e           state_q, state_d;
  logic [NBITS-1:0] x_q, x_d, m_q, m_d, y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] a_red;
  logic [NBITS-1:0] chain [PBITS+1];
  // Pre-reduce so the doubling invariant x < m holds from the first step.
  assign a_red    = (a >= m) ? a - m : a;
  assign chain[0] = x_q;
  for (genvar g = 0; g < PBITS; g++) begin : g_step
    mod_double_step #(.NBITS(NBITS)) u_step (.x(chain[g]), .m(m_q), .y(chain[g+1]));
  end
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    m_d     = m_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE && enable_p) begin
      m_d     = m;
      x_d     = a_red;
      cnt_d   = '0;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      x_d   = chain[PBITS];
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        y_d     = chain[PBITS];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      m_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  assign y          = y_q;
  assign done_irq_p = done_q;
endmodule

// File: tb/tb_montgomery_to_conv.sv
// tb_montgomery_to_conv: scoreboard bench over three configurations (8/1, 8/2, 64/2) against a modular-arithmetic reference.
module tb_montgomery_to_conv;
  typedef struct {
    logic [63:0] y;
    int          due;
  } exp_t;
  localparam int NB [3] = '{8, 8, 64};
  localparam int PB [3] = '{1, 2, 2};
  logic        clk, rst_n;
  logic        en [3];
  logic [63:0] ai [3];
  logic [63:0] mi [3];
  logic [63:0] yo [3];
  logic        dn [3];
  logic [7:0]  y0, y1;
  logic [63:0] y2;
  int          cyc, nchk, nerr;
  exp_t        q [3][$];
  montgomery_to_conv #(.NBITS(8), .PBITS(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .enable_p(en[0]), .a(ai[0][7:0]), .m(mi[0][7:0]), .y(y0), .done_irq_p(dn[0])
  );
  montgomery_to_conv #(.NBITS(8), .PBITS(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .enable_p(en[1]), .a(ai[1][7:0]), .m(mi[1][7:0]), .y(y1), .done_irq_p(dn[1])
  );
  montgomery_to_conv #(.NBITS(64), .PBITS(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .enable_p(en[2]), .a(ai[2]), .m(mi[2]), .y(y2), .done_irq_p(dn[2])
  );
  assign yo[0] = {56'b0, y0};
  assign yo[1] = {56'b0, y1};
  assign yo[2] = y2;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] ref_y(int nb, logic [63:0] av, logic [63:0] mv);
    logic [127:0] w;
    w = {64'b0, av} << nb;
    return 64'(w % {64'b0, mv});
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp_v);
    nchk++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask
  // Monitor: every completion pulse must match the oldest outstanding expectation, at its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (dn[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("spurious_done_d%0d", k), 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = q[k].pop_front();
            chk($sformatf("y_d%0d", k), yo[k], e.y);
            chk($sformatf("latency_d%0d", k), 64'(cyc), 64'(e.due));
          end
        end
      end
    end
  end
  task automatic start(int k, logic [63:0] av, logic [63:0] mv, bit expect_run = 1'b1);
    en[k] = 1'b1;
    ai[k] = av;
    mi[k] = mv;
    if (expect_run) q[k].push_back('{ref_y(NB[k], av, mv), cyc + 1 + NB[k] / PB[k]});
    @(negedge clk);
    en[k] = 1'b0;
    ai[k] = 64'(~av);
    mi[k] = 64'(~mv);
  endtask
  task automatic wait_done(int k);
    int t;
    t = 0;
    while (!dn[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!dn[k]) chk($sformatf("timeout_d%0d", k), 64'd0, 64'd1);
  endtask
  task automatic rand8(int k);
    logic [63:0] mv, av;
    mv = 64'($urandom_range(3, 255) | 1);
    av = 64'($urandom_range(0, (2 * mv - 1 > 255) ? 255 : int'(2 * mv - 1)));
    start(k, av, mv);
    wait_done(k);
  endtask
  initial begin
    nchk = 0;
    nerr = 0;
    cyc  = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0;
      ai[k] = '0;
      mi[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_y_d%0d", k), yo[k], 64'd0);
      chk($sformatf("reset_done_d%0d", k), 64'(dn[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start(0, 5, 13);
    repeat (4) @(negedge clk);
    chk("y_held_zero", yo[0], 64'd0);
    wait_done(0);
    @(negedge clk);
    chk("done_one_cycle", 64'(dn[0]), 64'd0);
    start(0, 1, 251);
    wait_done(0);
    start(0, 12, 13);
    wait_done(0);
    start(0, 0, 13);
    wait_done(0);
    start(0, 20, 13);
    wait_done(0);
    start(0, 13, 13);
    wait_done(0);
    @(negedge clk);
    start(1, 5, 13);
    start(1, 7, 11, 1'b0);
    start(1, 3, 7, 1'b0);
    wait_done(1);
    start(1, 9, 13);
    repeat (2) begin
      chk("y_kept_old", yo[1], 64'd6);
      @(negedge clk);
    end
    wait_done(1);
    @(negedge clk);
    start(0, 5, 13);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_y", yo[0], 64'd0);
    chk("abort_done", 64'(dn[0]), 64'd0);
    chk("abort_y_d1", yo[1], 64'd0);
    for (int k = 0; k < 3; k++) q[k].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start(0, 1, 251);
    wait_done(0);
    for (int i = 0; i < 8; i++) begin
      rand8(0);
      rand8(1);
    end
    for (int i = 0; i < 30; i++) begin
      logic [63:0] mv, av;
      mv = {$urandom, $urandom};
      mv[63] = 1'b1;
      mv[0]  = 1'b1;
      av = {$urandom, $urandom} % mv;
      if (i % 5 == 1) av = mv - 1;
      if (i % 5 == 3) av = mv + (av % (~mv + 64'd1));
      start(2, av, mv);
      wait_done(2);
    end
    begin
      int t;
      t = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("drain", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
